// File: rtl/fetch_redirect.sv
// Fetch redirect sequencer: flushes the pipe, then hands a jump
// target (EIP and/or CS) to fetch and holds it until fetch takes it.
module fetch_redirect #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        jump_load_address,
  input  logic [31:0] jump_address,
  input  logic        jump_load_cs,
  input  logic [31:0] jump_cs,
  input  logic        fetch_ready,
  output logic        flush,
  output logic        stall_ex,
  output logic        fetch_load_eip,
  output logic [31:0] fetch_eip,
  output logic        fetch_load_cs,
  output logic [31:0] fetch_cs,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       la_q;
  logic       lc_q;
  logic       req;

  assign req = ex_valid & (jump_load_address | jump_load_cs);

  // fetch_eip/fetch_cs double as the latched target registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      la_q           <= 1'b0;
      lc_q           <= 1'b0;
      flush          <= 1'b0;
      stall_ex       <= 1'b0;
      fetch_load_eip <= 1'b0;
      fetch_load_cs  <= 1'b0;
      fetch_eip      <= '0;
      fetch_cs       <= '0;
      redirect_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= FLUSH;
            cnt       <= CNT_INIT;
            fetch_eip <= jump_address;
            fetch_cs  <= jump_cs;
            la_q      <= jump_load_address;
            lc_q      <= jump_load_cs;
            flush     <= 1'b1;
            stall_ex  <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state          <= ISSUE;
            flush          <= 1'b0;
            fetch_load_eip <= la_q;
            fetch_load_cs  <= lc_q;
          end
        end
        ISSUE: begin
          if (fetch_ready) begin
            state          <= IDLE;
            stall_ex       <= 1'b0;
            fetch_load_eip <= 1'b0;
            fetch_load_cs  <= 1'b0;
            if (redirect_count != 16'hFFFF)
              redirect_count <= redirect_count + 16'd1;
          end
        end
        default: begin
          state          <= IDLE;
          flush          <= 1'b0;
          stall_ex       <= 1'b0;
          fetch_load_eip <= 1'b0;
          fetch_load_cs  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_redirect.md
FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush is held per redirect; legal range 1..15.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ex_valid  input  1  execute stage holds a valid retiring-candidate instruction this cycle.
REQ-006 jump_load_address  input  1  execute requests EIP reload.
REQ-007 jump_address  input  32  target EIP from execute.
REQ-008 jump_load_cs  input  1  execute requests CS reload (far jump).
REQ-009 jump_cs  input  32  target CS from execute.
REQ-010 fetch_ready  input  1  fetch unit accepts the redirect this cycle.
REQ-011 flush  output  1  kill all younger in-flight instructions in fetch/decode/execute.
REQ-012 stall_ex  output  1  execute must hold; new jump requests are not accepted.
REQ-013 fetch_load_eip  output  1  fetch must load fetch_eip.
REQ-014 fetch_eip  output  32  redirect EIP.
REQ-015 fetch_load_cs  output  1  fetch must load fetch_cs.
REQ-016 fetch_cs  output  32  redirect CS.
REQ-017 redirect_count  output  16  number of completed redirects, saturating.

Function
REQ-018 The block SHALL be a Moore FSM with states IDLE, FLUSH, ISSUE and a 4-bit flush counter.
REQ-019 Request = ex_valid & (jump_load_address | jump_load_cs), sampled only in IDLE.
REQ-020 IDLE + request: latch jump_address, jump_cs, jump_load_address, jump_load_cs; counter <= FLUSH_CYCLES-1; next state FLUSH.
REQ-021 IDLE + no request: remain IDLE; latched registers unchanged.
REQ-022 FLUSH: flush=1; counter nonzero -> decrement, stay; counter zero -> next state ISSUE.
REQ-023 Latency: request at cycle N -> flush high exactly cycles N+1..N+FLUSH_CYCLES; ISSUE entered at N+FLUSH_CYCLES+1.
REQ-024 ISSUE: fetch_load_eip = latched jump_load_address, fetch_load_cs = latched jump_load_cs, fetch_eip/fetch_cs = latched values; held stable until fetch_ready.
REQ-025 ISSUE + fetch_ready: next state IDLE; redirect_count increments by 1 unless at 16'hFFFF (saturate).
REQ-026 ISSUE + !fetch_ready: stay in ISSUE indefinitely, outputs unchanged.
REQ-027 fetch_ready outside ISSUE SHALL be ignored.
REQ-028 stall_ex = 1 whenever state != IDLE; requests in FLUSH/ISSUE are ignored and not queued.
REQ-029 fetch_load_eip and fetch_load_cs SHALL be 0 outside ISSUE; flush SHALL be 0 outside FLUSH.
REQ-030 CS-only request (jump_load_cs=1, jump_load_address=0): fetch_load_eip=0 in ISSUE, fetch_eip still drives latched value.
REQ-031 Back-to-back: request present in the IDLE cycle immediately after ISSUE exit SHALL be accepted (no dead cycle beyond that IDLE cycle).

Reset
REQ-032 reset=1 at a rising edge SHALL force IDLE, counter 0, latched address/CS 0, latched flags 0, redirect_count 0.
REQ-033 Output reset values: flush 0, stall_ex 0, fetch_load_eip 0, fetch_eip 0, fetch_load_cs 0, fetch_cs 0, redirect_count 0.
REQ-034 Reset SHALL take priority over a simultaneous request or fetch_ready and SHALL abort FLUSH/ISSUE mid-operation without counting the redirect.

Verification
REQ-035 Near jump, FLUSH_CYCLES=2: request N with jump_address=0x0000_1234, load_address=1, fetch_ready=1 always -> flush high N+1,N+2; ISSUE N+3 with fetch_load_eip=1, fetch_eip=0x1234, fetch_load_cs=0; IDLE N+4; redirect_count=1.
REQ-036 Far jump with fetch backpressure: jump_address=0x10, jump_cs=0x20, both loads=1, fetch_ready low 5 cycles in ISSUE -> outputs stable 0x10/0x20, stall_ex=1 throughout, exit one cycle after fetch_ready rises.
REQ-037 Request during FLUSH with different address 0xBEEF -> ignored; ISSUE drives first address; redirect_count increments by 1 only.
REQ-038 Reset asserted in ISSUE with fetch_ready=1 same cycle -> next cycle IDLE, all outputs 0, redirect_count unchanged from 0.
REQ-039 Counter preloaded to 0xFFFE via 2 further redirects -> reads 0xFFFF, stays 0xFFFF.
REQ-040 FLUSH_CYCLES=1 and 15: flush width exactly 1 and 15 cycles respectively; ex_valid=0 with load flags high -> no redirect.
